// File: rtl/keypad_digit_capture.sv
// keypad_digit_capture: decodes scanner key presses into a two-digit hex history,
// accepting one digit per physical press via a press/release lockout.
module keypad_digit_capture #(
  parameter int RELEASE_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic       change,
  output logic [7:0] digits,
  output logic       new_digit,
  output logic       key_held
);
  localparam int CW = $clog2(RELEASE_CYCLES + 1);
  // Nibble k holds the code for row*4+col.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {ARMED, HELD, RELEASE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] digits_n;
  logic new_n;
  logic row_ok, col_ok, valid;
  logic [1:0] row_idx, col_idx;
  logic [3:0] code;
  assign row_ok  = (rows != 4'b0) && ((rows & (rows - 4'd1)) == 4'b0);
  assign col_ok  = (cols != 4'b0) && ((cols & (cols - 4'd1)) == 4'b0);
  assign valid   = change && row_ok && col_ok;
  assign row_idx = {rows[3] | rows[2], rows[3] | rows[1]};
  assign col_idx = {cols[3] | cols[2], cols[3] | cols[1]};
  assign code    = KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARMED;
      cnt       <= '0;
      digits    <= 8'h00;
      new_digit <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      digits    <= digits_n;
      new_digit <= new_n;
    end
  end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    digits_n = digits;
    new_n    = 1'b0;
    case (state)
      ARMED: begin
        if (valid) begin
          digits_n = {digits[3:0], code};
          new_n    = 1'b1;
          state_n  = HELD;
        end
      end
      HELD: begin
        if (cols == 4'b0) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        if (cols != 4'b0) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == CW'(RELEASE_CYCLES - 1)) begin
          state_n = ARMED;
          cnt_n   = '0;
        end else begin
          cnt_n = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
        end
      end
      default: begin
        state_n = ARMED;
        cnt_n   = '0;
      end
    endcase
  end
  always_comb key_held = (state != ARMED);
endmodule

// File: tb/tb_keypad_digit_capture.sv
// tb_keypad_digit_capture: directed tests of capture, lockout, bounce, invalid samples and reset.
module tb_keypad_digit_capture;
  localparam int R = 32;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows = 4'b0;
  logic [3:0] cols = 4'b0;
  logic       change = 1'b0;
  logic [7:0] digits;
  logic       new_digit;
  logic       key_held;
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  keypad_digit_capture #(.RELEASE_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols), .change(change),
    .digits(digits), .new_digit(new_digit), .key_held(key_held)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (new_digit === 1'b1) pulses++;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    change = 1'b0;
    cyc(1);
    reset = 1'b1;
  endtask

  task automatic press(input logic [3:0] r, input logic [3:0] c);
    rows = r;
    cols = c;
    change = 1'b1;
    cyc(1);
    change = 1'b0;
  endtask

  task automatic release_key();
    rows = 4'b0;
    cols = 4'b0;
    cyc(R + 1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(2);
    checks++;
    if (digits !== 8'h00 || new_digit !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits=%h new=%b held=%b, required 00 0 0", digits, new_digit, key_held);
    end
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_first_digit();
    int p0;
    p0 = pulses;
    press(4'b0010, 4'b0100);
    checks++;
    if (digits !== 8'h06 || new_digit !== 1'b1 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL first_digit: digits=%h new=%b held=%b, required 06 1 1", digits, new_digit, key_held);
    end
    cyc(1);
    checks++;
    if (new_digit !== 1'b0 || pulses - p0 !== 1) begin
      errors++;
      $display("FAIL first_pulse_width: new=%b pulses=%0d, required 0 1", new_digit, pulses - p0);
    end
  endtask

  task automatic test_two_digits();
    int p0;
    do_reset();
    p0 = pulses;
    press(4'b0001, 4'b0001);
    checks++;
    if (digits !== 8'h01) begin
      errors++;
      $display("FAIL digit_1: digits=%h, required 01", digits);
    end
    rows = 4'b0;
    cols = 4'b0;
    cyc(R);
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL rearm_early: held=%b, required 1", key_held);
    end
    cyc(1);
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL rearm_on_time: held=%b, required 0", key_held);
    end
    press(4'b1000, 4'b1000);
    cyc(1);
    checks++;
    if (digits !== 8'h1D || pulses - p0 !== 2) begin
      errors++;
      $display("FAIL digit_1D: digits=%h pulses=%0d, required 1D 2", digits, pulses - p0);
    end
  endtask

  task automatic test_hold_repeat();
    int p0;
    do_reset();
    p0 = pulses;
    press(4'b0010, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      press(4'b0010, 4'b0010);
      cyc(1);
    end
    checks++;
    if (digits !== 8'h05 || pulses - p0 !== 1 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL hold_repeat: digits=%h pulses=%0d held=%b, required 05 1 1", digits, pulses - p0, key_held);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulses;
    rows = 4'b0;
    cols = 4'b0;
    cyc(R - 2);
    press(4'b0001, 4'b0001);
    rows = 4'b0;
    cols = 4'b0;
    cyc(3);
    checks++;
    if (key_held !== 1'b1 || pulses - p0 !== 0 || digits !== 8'h05) begin
      errors++;
      $display("FAIL bounce_ignored: held=%b pulses=%0d digits=%h, required 1 0 05", key_held, pulses - p0, digits);
    end
    cyc(R - 3);
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL bounce_rearm_early: held=%b, required 1", key_held);
    end
    cyc(1);
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL bounce_rearm: held=%b, required 0", key_held);
    end
    press(4'b0100, 4'b0001);
    checks++;
    if (digits !== 8'h57 || new_digit !== 1'b1) begin
      errors++;
      $display("FAIL after_bounce: digits=%h new=%b, required 57 1", digits, new_digit);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] r_v [3];
    logic [3:0] c_v [3];
    r_v = '{4'b0011, 4'b0001, 4'b0001};
    c_v = '{4'b0001, 4'b0110, 4'b0000};
    release_key();
    for (int i = 0; i < 3; i++) begin
      press(r_v[i], c_v[i]);
      checks++;
      if (new_digit !== 1'b0 || digits !== 8'h57 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL invalid_%0d: new=%b digits=%h held=%b, required 0 57 0", i, new_digit, digits, key_held);
      end
      rows = 4'b0;
      cols = 4'b0;
      cyc(1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(4'b0001, 4'b0100);
    release_key();
    press(4'b0001, 4'b1000);
    checks++;
    if (digits !== 8'h3A || key_held !== 1'b1) begin
      errors++;
      $display("FAIL setup_3A: digits=%h held=%b, required 3A 1", digits, key_held);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (digits !== 8'h00 || key_held !== 1'b0 || new_digit !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: digits=%h held=%b new=%b, required 00 0 0", digits, key_held, new_digit);
    end
    cyc(1);
    reset = 1'b1;
    press(4'b0001, 4'b1000);
    checks++;
    if (digits !== 8'h0A || new_digit !== 1'b1 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_capture: digits=%h new=%b held=%b, required 0A 1 1", digits, new_digit, key_held);
    end
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_two_digits();
    test_hold_repeat();
    test_bounce();
    test_invalid();
    test_reset_mid();
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
